// File: rtl/ps2_rx_decoder.sv
// -----------------------------------------------------------------------------
// ps2_rx_decoder
//
// PS/2 device-to-host receiver. The raw ps2_clk/ps2_data lines are brought into
// the clk domain, ps2_clk is debounced, and 11-bit frames are deframed on the
// falling edges of the filtered clock. The E0 (extended) and F0 (release)
// prefix bytes are folded into flags, so each key event is one key_ready
// strobe carrying an 8-bit code and two qualifier bits.
//
// Configuration macro:
//   PS2_PARITY_CHECK_EN  defined   : a frame with bad odd parity is dropped
//                                    and frame_err is pulsed.
//                        undefined : the parity bit is clocked past and
//                                    ignored. Only stop-bit and timeout errors
//                                    raise frame_err.
//
// Parameters:
//   FILTER_LEN      consecutive equal synchronised samples needed to change
//                   the filtered ps2_clk
//   TIMEOUT_CYCLES  max clk cycles allowed between falling edges in a frame
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock (asynchronous, idle high)
//   ps2_data     in   raw PS/2 data (asynchronous, idle high)
//   key_code     out  last reported scan code, with prefixes stripped
//   key_ext      out  key_code was preceded by E0
//   key_release  out  key_code was preceded by F0
//   key_ready    out  one-cycle strobe: key_code and flags updated this cycle
//   frame_err    out  one-cycle strobe: frame dropped (stop/parity/timeout)
// -----------------------------------------------------------------------------
module ps2_rx_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_ready,
  output logic       frame_err
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCNT_W  = $clog2(FILTER_LEN + 1);

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_REL = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. They reset to the idle-high level of the bus, so
  // releasing reset never produces a spurious falling edge.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;

  // NOTE: every clocked block uses non-blocking assignments, so each register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  logic data_s;
  assign data_s = data_sync[1];

  // ---------------------------------------------------------------------------
  // ps2_clk glitch filter. The filtered level changes only after FILTER_LEN
  // consecutive synchronised samples disagree with it. Any agreeing sample
  // restarts the count, so short spikes never get through.
  // ---------------------------------------------------------------------------
  logic              clk_filt;
  logic              clk_filt_d;
  logic [FCNT_W-1:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // The edge is seen in the cycle after the filtered level drops. The
  // synchronised data is sampled in that same cycle. The device holds data
  // stable for the whole low phase, which is far longer than the filter delay.
  logic fall_edge;
  assign fall_edge = clk_filt_d & ~clk_filt;

  // ---------------------------------------------------------------------------
  // Frame FSM, prefix tracking and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift_reg;
  logic               ext_flag;
  logic               rel_flag;
  logic [TIMER_W-1:0] timer;
  logic               frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  // Odd parity: the data ones plus the parity bit must add up to an odd count.
  assign frame_ok = data_s & (^{shift_reg, parity_bit});
`else
  assign frame_ok = data_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      timer       <= '0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_ready   <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      // Both strobes are single-cycle. They are only raised below.
      key_ready <= 1'b0;
      frame_err <= 1'b0;

      if (fall_edge) begin
        // When a falling edge and a timeout land in the same cycle, the edge
        // wins: the edge branch is taken and the timer simply restarts.
        timer <= '0;
        unique case (state)
          S_IDLE: begin
            // A high start bit is line noise; wait for a real start bit.
            if (!data_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end

          S_DATA: begin
            // Data arrives LSB first.
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end

          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= data_s;
`endif
            state <= S_STOP;
          end

          S_STOP: begin
            state <= S_IDLE;
            if (frame_ok) begin
              if (shift_reg == BYTE_EXT) begin
                ext_flag <= 1'b1;
              end else if (shift_reg == BYTE_REL) begin
                rel_flag <= 1'b1;
              end else begin
                key_code    <= shift_reg;
                key_ext     <= ext_flag;
                key_release <= rel_flag;
                key_ready   <= 1'b1;
                ext_flag    <= 1'b0;
                rel_flag    <= 1'b0;
              end
            end else begin
              // A dropped frame breaks any prefix sequence in progress.
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              rel_flag  <= 1'b0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Inside a frame the timer measures the gap since the last falling
        // edge. A stalled device is abandoned after TIMEOUT_CYCLES.
        if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state     <= S_IDLE;
          timer     <= '0;
          frame_err <= 1'b1;
          ext_flag  <= 1'b0;
          rel_flag  <= 1'b0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx_decoder
//
// Bench for ps2_rx_decoder. The stimulus side drives PS/2 frames. For each
// frame it asks a behavioural model, which works at the byte/event level,
// what the decoder should report, and pushes that report onto a queue. A
// separate monitor pops one entry every time the DUT pulses key_ready or
// frame_err and compares the two.
// -----------------------------------------------------------------------------
module tb_ps2_rx_decoder;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int HALF           = 20;  // PS/2 half period in clk cycles
  localparam int GLITCH         = 2;   // glitch width, shorter than the filter

  // Frame kinds
  localparam int K_GOOD    = 0;
  localparam int K_BADSTOP = 1;
  localparam int K_BADPAR  = 2;
  localparam int K_TIMEOUT = 3;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_ready;
  logic       frame_err;

  ps2_rx_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_ready  (key_ready),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         ext;
    bit         rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: byte-level view of the protocol
  // ---------------------------------------------------------------------------
  bit         m_ext  = 1'b0;
  bit         m_rel  = 1'b0;
  logic [7:0] m_code = 8'h00;  // last reported code, used for hold checks

  task automatic model_frame(input logic [7:0] b, input int kind);
    exp_t e;
    bit   dropped;
    dropped = (kind == K_BADSTOP) || (kind == K_TIMEOUT);
`ifdef PS2_PARITY_CHECK_EN
    if (kind == K_BADPAR) dropped = 1'b1;
`endif
    if (dropped) begin
      e = '{err: 1'b1, code: m_code, ext: 1'b0, rel: 1'b0};
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      e = '{err: 1'b0, code: b, ext: m_ext, rel: m_rel};
      exp_q.push_back(e);
      m_code = b;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // PS/2 line driver
  // ---------------------------------------------------------------------------
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    repeat (HALF / 2) @(posedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (GLITCH) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind, input bit glitch);
    logic par;
    model_frame(b, kind);
    par = ~(^b);
    if (kind == K_BADPAR) par = ~par;
    ps2_bit(1'b0, 1'b0);
    if (kind == K_TIMEOUT) begin
      for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
      ps2_data = 1'b1;
      repeat (2 * TIMEOUT_CYCLES) @(posedge clk);
    end else begin
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 3));
      ps2_bit(par, 1'b0);
      ps2_bit((kind == K_BADSTOP) ? 1'b0 : 1'b1, 1'b0);
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && (key_ready || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, key_ready, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {30'd0, key_ready, frame_err}, e.err ? 32'd1 : 32'd2);
        if (e.err) begin
          check("code_hold", {24'd0, key_code}, {24'd0, e.code});
        end else begin
          check("key_code", {24'd0, key_code}, {24'd0, e.code});
          check("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
          check("key_release", {31'd0, key_release}, {31'd0, e.rel});
        end
      end
    end
  end

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] b;
    int         r;
    int         kind;

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_key_code", {24'd0, key_code}, 32'd0);
    check("rst_flags", {28'd0, key_ext, key_release, key_ready, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Directed cases
    send_frame(8'h6B, K_GOOD, 1'b0);
    send_frame(8'hE0, K_GOOD, 1'b0);
    send_frame(8'h74, K_GOOD, 1'b0);
    send_frame(8'hE0, K_GOOD, 1'b0);
    send_frame(8'hF0, K_GOOD, 1'b0);
    send_frame(8'h75, K_GOOD, 1'b0);
    send_frame(8'h72, K_GOOD, 1'b0);
    send_frame(8'h6B, K_BADSTOP, 1'b0);
    send_frame(8'h6B, K_TIMEOUT, 1'b0);
    send_frame(8'h72, K_GOOD, 1'b0);
    send_frame(8'h6B, K_BADPAR, 1'b0);
    send_frame(8'h6B, K_GOOD, 1'b1);
    // A dropped frame must discard a pending prefix
    send_frame(8'hE0, K_GOOD, 1'b0);
    send_frame(8'h11, K_BADSTOP, 1'b0);
    send_frame(8'h74, K_GOOD, 1'b0);
    // Repeated prefixes keep the flags set
    send_frame(8'hE0, K_GOOD, 1'b0);
    send_frame(8'hE0, K_GOOD, 1'b0);
    send_frame(8'hF0, K_GOOD, 1'b0);
    send_frame(8'hF0, K_GOOD, 1'b0);
    send_frame(8'h6B, K_GOOD, 1'b0);
    drain("drain_directed");

    // Randomised traffic
    for (int n = 0; n < 50; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 99));
      if (r < 10)      kind = K_BADSTOP;
      else if (r < 20) kind = K_BADPAR;
      else if (r < 24) kind = K_TIMEOUT;
      else             kind = K_GOOD;
      send_frame(b, kind, ($urandom_range(0, 3) == 0));
    end
    drain("drain_random");

    // Reset in the middle of a frame, with an E0 prefix pending
    send_frame(8'hE0, K_GOOD, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst    = 1'b0;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_code = 8'h00;
    @(negedge clk);
    check("midrst_key_code", {24'd0, key_code}, 32'd0);
    check("midrst_flags", {30'd0, key_ext, key_release}, 32'd0);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    send_frame(8'h75, K_GOOD, 1'b0);
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
